// File: rtl/sub16_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
// Combinational definitions only; no latency and no flow control.
package sub16_pkg;

    localparam int unsigned SUB_WIDTH = 16;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_w(SUB_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin.
// Purely combinational, zero latency, no flow control.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial X - Y, LSB first, one bit per clock through a single full_sub.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module sub16_serial
    import sub16_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b,
    output logic             v,
    output logic             z
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic             r_arm;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-2:0] r_dsh;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_dfull;

    // r_arm stays low for the first edge after reset release so a start there is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm <= 1'b0;
        end else begin
            r_arm <= 1'b1;
        end
    end

    assign w_accept = r_arm && start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_dfull  = {w_d, r_dsh};
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

    full_sub u_full_sub (
        .a    (r_x[0]),
        .b    (r_y[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_dsh <= '0;
            r_cnt <= '0;
            r_bin <= 1'b0;
            d     <= '0;
            b     <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b1;
        end else if (w_accept) begin
            r_x   <= X;
            r_y   <= Y;
            r_cnt <= '0;
            r_bin <= 1'b0;
        end else if (r_state == RUN) begin
            r_x   <= r_x >> 1;
            r_y   <= r_y >> 1;
            r_dsh <= w_dfull[WIDTH-1:1];
            r_bin <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            // On the last bit r_x[0]/r_y[0] are the operand MSBs.
            if (w_last) begin
                d <= w_dfull;
                b <= w_bout;
                v <= (r_x[0] != r_y[0]) && (w_d != r_x[0]);
                z <= (w_dfull == '0);
            end
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// Randomized scoreboard bench for sub16_serial against an arithmetic reference model.
module tb_sub16_serial;

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic        v;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        b;
    logic        v;
    logic        z;

    res_t exp_q[$];
    int   done_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    res_t prev;

    always #5 clk = ~clk;

    sub16_serial #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b     (b),
        .v     (v),
        .z     (z)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        res_t r;
        int   sdiff;
        r.d   = x - y;
        r.b   = (x < y);
        sdiff = int'($signed(x)) - int'($signed(y));
        r.v   = (sdiff > 32767) || (sdiff < -32768);
        r.z   = (r.d == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at cycle %0d", nm, got, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks outputs hold while busy.
    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done got d=%h b=%b v=%b z=%b expected no done", d, b, v, z);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_dbvz", 32'({d, b, v, z}), 32'(e));
                end
                done_cyc.push_back(cyc);
            end else if (busy) begin
                chk("hold_while_busy", 32'({d, b, v, z}), 32'(prev));
            end
            prev = {d, b, v, z};
        end
    end

    task automatic check_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_d"},    32'(d),    32'd0);
        chk({nm, "_b"},    32'(b),    32'd0);
        chk({nm, "_v"},    32'(v),    32'd0);
        chk({nm, "_z"},    32'(z),    32'd1);
    endtask

    // Issues one start, scrambles X/Y while busy, and checks start-to-done latency.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y);
        int lat;
        bit seen;
        X     = x;
        Y     = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                X     = 16'($urandom);
                Y     = 16'($urandom);
            end
            if (done) seen = 1'b1;
        end
        chk("latency", 32'(lat), 32'd17);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'h0005, 16'h0003);
        run_op(16'h0000, 16'h0001);
        run_op(16'h8000, 16'h0001);
        run_op(16'h1234, 16'h1234);
        run_op(16'h7FFF, 16'hFFFF);
        run_op(16'hFFFF, 16'hFFFF);

        // Abort mid-operation, then start during the reset release cycle.
        X     = 16'hFFFF;
        Y     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        X     = 16'h0009;
        Y     = 16'h0004;
        @(posedge clk);
        #1;
        chk("start_in_release_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_after_abort", 32'(done_cyc.size()), 32'd6);
        run_op(16'h0003, 16'h0001);
        repeat (2) @(posedge clk);
        #1;

        // Start held high: back-to-back operations with done every 17 cycles.
        n0    = done_cyc.size();
        X     = 16'h0007;
        Y     = 16'h0002;
        start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(16'h0007, 16'h0002));
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("held_done_count", 32'(done_cyc.size() - n0), 32'd3);
        if (done_cyc.size() - n0 == 3) begin
            chk("held_period_1", 32'(done_cyc[n0 + 1] - done_cyc[n0]), 32'd17);
            chk("held_period_2", 32'(done_cyc[n0 + 2] - done_cyc[n0 + 1]), 32'd17);
        end

        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout reached cycle %0d required completion earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; all widths below are expressed as WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin d = X - Y.
REQ-006 Port: X  input  WIDTH  minuend, sampled only on an accepted start.
REQ-007 Port: Y  input  WIDTH  subtrahend, sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when results are valid.
REQ-010 Port: d  output  WIDTH  difference X - Y, modulo 2^WIDTH.
REQ-011 Port: b  output  1  borrow out; high when X < Y unsigned.
REQ-012 Port: v  output  1  signed overflow of X - Y.
REQ-013 Port: z  output  1  high when d == 0.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 Transitions: IDLE->RUN on start; RUN->DONE after WIDTH bit cycles; DONE->RUN on start, else DONE->IDLE.
REQ-016 Start is accepted only in IDLE or DONE; start while busy=1 SHALL be ignored and SHALL leave operands unchanged.
REQ-017 On acceptance, X and Y SHALL be latched, the bit counter cleared and the internal borrow set to 0.
REQ-018 In RUN, one bit per cycle, LSB first: d_i = X_i ^ Y_i ^ bin; bout = (~X_i & Y_i) | (~(X_i ^ Y_i) & bin).
REQ-019 Latency: start sampled at edge N -> busy high from N+1 through N+WIDTH; done high for exactly cycle N+WIDTH+1.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH))+1 bits and SHALL NOT wrap within an operation.
REQ-021 b SHALL equal the final borrow out of bit WIDTH-1.
REQ-022 v SHALL equal (X[MSB] != Y[MSB]) && (d[MSB] != X[MSB]) using latched operands.
REQ-023 z SHALL equal (d == 0).
REQ-024 d, b, v and z SHALL update only when done asserts and SHALL hold until the next done.
REQ-025 d, b, v and z SHALL NOT change while busy=1; partial results stay internal.
REQ-026 Start coincident with done (state DONE) SHALL be accepted with no idle cycle; done deasserts in the next cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE; busy=0, done=0, d=0, b=0, v=0, z=1; counter and borrow cleared.
REQ-028 Reset mid-operation SHALL abort without a done pulse; the first start after rst_n rises SHALL be accepted normally.
REQ-029 Reset release SHALL be synchronous to clk; start in the release cycle SHALL be ignored.

Structure
REQ-030 Package sub16_pkg SHALL hold the WIDTH default, the counter width constant and the state enum type.
REQ-031 A 1-bit combinational sub-module, full_sub (a, b, bin -> d, bout), SHALL be instantiated once per bit cycle.
REQ-032 Operands SHALL be held in shift registers; no WIDTH-wide combinational subtractor is permitted.

Verification
REQ-033 X=5, Y=3, start one cycle -> done after 17 cycles, d=0x0002, b=0, v=0, z=0.
REQ-034 X=0x0000, Y=0x0001 -> d=0xFFFF, b=1, v=0, z=0.
REQ-035 X=0x8000, Y=0x0001 -> d=0x7FFF, b=0, v=1; X=0x1234, Y=0x1234 -> d=0, z=1, b=0.
REQ-036 Start held high for 40 cycles, X=7, Y=2 -> done pulses every 17 cycles; a second start at done yields back-to-back d=0x0005 with no IDLE cycle.
REQ-037 rst_n low at bit 8 of X=0xFFFF, Y=0x0001 -> outputs at reset values, no done; next operation X=3, Y=1 -> d=0x0002.
REQ-038 Change X/Y while busy -> result reflects the latched operands; the self-check compares against a (X - Y) mod 2^16 model over 1000 random pairs.
